// File: rtl/fwd_scoreboard_pkg.sv
// Shared core defines for the forwarding scoreboard: register-index width,
// default ALU latency, and the destination record carried through the slots.
package fwd_scoreboard_pkg;

  localparam int REG_IDX_W       = 5;
  localparam int ALU_LAT_DEFAULT = 3;
  localparam int STALL_CNT_W     = 16;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic                 wr;
  } dst_t;

endpackage

// File: rtl/fwd_slot_match.sv
// Tests one in-flight slot against one decode source operand.
module fwd_slot_match
  import fwd_scoreboard_pkg::*;
(
  input  logic                 valid,
  input  logic                 wr,
  input  logic [REG_IDX_W-1:0] rd,
  input  logic [REG_IDX_W-1:0] src,
  input  logic                 use_src,
  output logic                 match
);

  assign match = valid & wr & (rd == src) & (src != '0) & use_src;

endmodule

// File: rtl/fwd_scoreboard.sv
// Issue scoreboard for a fixed-latency ALU: stalls on young producers and
// selects MEM/WB forwarding for producers whose result is already available.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int ALU_LAT = ALU_LAT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [REG_IDX_W-1:0]   id_rs1,
  input  logic [REG_IDX_W-1:0]   id_rs2,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  logic [REG_IDX_W-1:0]   id_rd,
  input  logic                   id_regwrite,
  input  logic                   flush,
  output logic                   issue,
  output logic                   stall,
  output logic                   MEM_fwd1_reg,
  output logic                   MEM_fwd2_reg,
  output logic                   WB_fwd1_reg,
  output logic                   WB_fwd2_reg,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  logic [ALU_LAT:0]   vld_q;
  dst_t               dst_q [0:ALU_LAT];
  logic [ALU_LAT:0]   match1;
  logic [ALU_LAT:0]   match2;
  logic [ALU_LAT-1:0] keep_mask;
  logic               hazard;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + STALL_CNT_W'(1);
  endfunction

  for (genvar k = 0; k <= ALU_LAT; k++) begin : g_slot
    fwd_slot_match u_rs1 (
      .valid(vld_q[k]), .wr(dst_q[k].wr), .rd(dst_q[k].rd),
      .src(id_rs1), .use_src(id_use_rs1), .match(match1[k])
    );
    fwd_slot_match u_rs2 (
      .valid(vld_q[k]), .wr(dst_q[k].wr), .rd(dst_q[k].rd),
      .src(id_rs2), .use_src(id_use_rs2), .match(match2[k])
    );
  end

  // Decode stage: hazard resolution, issue and forward selection
  always_comb begin
    hazard       = (|match1[ALU_LAT-2:0]) | (|match2[ALU_LAT-2:0]);
    stall        = ~rst & id_valid & ~flush & hazard;
    issue        = ~rst & id_valid & ~flush & ~hazard;
    MEM_fwd1_reg = issue & match1[ALU_LAT-1];
    MEM_fwd2_reg = issue & match2[ALU_LAT-1];
    WB_fwd1_reg  = issue & match1[ALU_LAT] & ~match1[ALU_LAT-1];
    WB_fwd2_reg  = issue & match2[ALU_LAT] & ~match2[ALU_LAT-1];
    // A flush squashes everything younger than the MEM slot, which then moves to WB.
    keep_mask    = '1;
    if (flush) keep_mask = {1'b1, {(ALU_LAT-1){1'b0}}};
  end

  // Slot shift register: destination payload
  always_ff @(posedge clk) begin
    dst_q[0] <= '{rd: id_rd, wr: id_regwrite & (id_rd != '0)};
    for (int k = 1; k <= ALU_LAT; k++) dst_q[k] <= dst_q[k-1];
  end

  // Slot shift register: valid bits and stall statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q        <= '0;
      stall_cycles <= '0;
    end else begin
      vld_q <= {vld_q[ALU_LAT-1:0] & keep_mask, issue};
      if (stall) stall_cycles <= sat_inc(stall_cycles);
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard (ALU_LAT=3) with an age-based reference model.
module tb_fwd_scoreboard;

  localparam int AL = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_rs1, id_use_rs2, id_regwrite, flush;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        issue, stall, MEM_fwd1_reg, MEM_fwd2_reg, WB_fwd1_reg, WB_fwd2_reg;
  logic [15:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  fwd_scoreboard #(.ALU_LAT(AL)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .flush(flush), .issue(issue), .stall(stall),
    .MEM_fwd1_reg(MEM_fwd1_reg), .MEM_fwd2_reg(MEM_fwd2_reg),
    .WB_fwd1_reg(WB_fwd1_reg), .WB_fwd2_reg(WB_fwd2_reg), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Reference model: list of live producers tagged with their issue cycle.
  typedef struct { int cyc; logic [4:0] rd; } prod_t;
  prod_t      q[$];
  int         cyc;
  int         exp_cnt;
  logic       exp_issue, exp_stall;
  logic [5:0] exp_vec;

  function automatic logic [5:0] vec();
    return {issue, stall, MEM_fwd1_reg, MEM_fwd2_reg, WB_fwd1_reg, WB_fwd2_reg};
  endfunction

  function automatic void src_status(input logic [4:0] s, input logic u,
                                     output bit hz, output bit mem, output bit wb);
    hz = 0; mem = 0; wb = 0;
    if (!u || s == 5'd0) return;
    foreach (q[i]) begin
      int age = cyc - q[i].cyc;
      if (q[i].rd == s) begin
        if (age >= 1 && age <= AL-1) hz = 1;
        if (age == AL) mem = 1;
        if (age == AL+1) wb = 1;
      end
    end
  endfunction

  function automatic void model_eval();
    bit h1, m1, w1, h2, m2, w2;
    src_status(id_rs1, id_use_rs1, h1, m1, w1);
    src_status(id_rs2, id_use_rs2, h2, m2, w2);
    exp_stall = id_valid & ~flush & (h1 | h2);
    exp_issue = id_valid & ~flush & ~exp_stall;
    exp_vec   = {exp_issue, exp_stall, exp_issue & m1, exp_issue & m2,
                 exp_issue & w1 & ~m1, exp_issue & w2 & ~m2};
  endfunction

  task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2,
                       input logic [4:0] rd, input logic rw, input logic fl);
    id_valid = v; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = rw; flush = fl;
    #1;
    model_eval();
  endtask

  task automatic tick();
    prod_t nq[$];
    @(posedge clk);
    if (exp_stall && exp_cnt != 65535) exp_cnt++;
    foreach (q[i]) begin
      int age = cyc - q[i].cyc;
      if (!(flush && age >= 1 && age <= AL-1) && age < AL+1) nq.push_back(q[i]);
    end
    if (exp_issue && id_regwrite && id_rd != 5'd0) nq.push_back('{cyc, id_rd});
    q = nq;
    cyc++;
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic writer(input logic [4:0] rd);
    drive(1, 0, 0, 0, 0, rd, 1, 0);
    tick();
  endtask

  task automatic reset_dut();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete(); cyc = 0; exp_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
    n_checks++;
    if (vec() !== 6'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want %b", vec(), 6'b0);
    end
    n_checks++;
    if (stall_cycles !== 16'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", stall_cycles);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete(); cyc = 0; exp_cnt = 0;
    nop();
  endtask

  task automatic test_mem_wb_fwd();
    reset_dut();
    writer(5'd5); nop(); nop();
    drive(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0);
    n_checks++;
    if (vec() !== 6'b101000) begin
      n_fail++; $display("FAIL mem_fwd1: got %b want %b", vec(), 6'b101000);
    end
    tick();
    reset_dut();
    writer(5'd5); nop(); nop(); nop();
    drive(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0);
    n_checks++;
    if (vec() !== 6'b100010) begin
      n_fail++; $display("FAIL wb_fwd1: got %b want %b", vec(), 6'b100010);
    end
    tick();
  endtask

  task automatic test_stall();
    reset_dut();
    writer(5'd7);
    for (int i = 0; i < 2; i++) begin
      drive(1, 5'd0, 0, 5'd7, 1, 5'd0, 0, 0);
      n_checks++;
      if (vec() !== 6'b010000) begin
        n_fail++; $display("FAIL stall_cycle%0d: got %b want %b", i, vec(), 6'b010000);
      end
      tick();
    end
    drive(1, 5'd0, 0, 5'd7, 1, 5'd0, 0, 0);
    n_checks++;
    if (vec() !== 6'b100100) begin
      n_fail++; $display("FAIL stall_release_mem2: got %b want %b", vec(), 6'b100100);
    end
    tick();
    n_checks++;
    if (stall_cycles !== 16'd2) begin
      n_fail++; $display("FAIL stall_count: got %0d want 2", stall_cycles);
    end
  endtask

  task automatic test_youngest_wins();
    reset_dut();
    writer(5'd3); writer(5'd3); nop(); nop();
    drive(1, 5'd3, 1, 5'd3, 1, 5'd0, 0, 0);
    n_checks++;
    if (vec() !== 6'b101100) begin
      n_fail++; $display("FAIL youngest_wins: got %b want %b", vec(), 6'b101100);
    end
    tick();
  endtask

  task automatic test_no_hazard();
    reset_dut();
    writer(5'd0);
    drive(1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0);
    n_checks++;
    if (vec() !== 6'b100000) begin
      n_fail++; $display("FAIL x0_writer: got %b want %b", vec(), 6'b100000);
    end
    tick();
    writer(5'd9);
    drive(1, 5'd9, 0, 5'd0, 0, 5'd0, 0, 0);
    n_checks++;
    if (vec() !== 6'b100000) begin
      n_fail++; $display("FAIL unused_rs1: got %b want %b", vec(), 6'b100000);
    end
    tick();
    drive(1, 5'd4, 1, 5'd0, 0, 5'd4, 0, 0);
    tick();
    drive(1, 5'd4, 1, 5'd4, 1, 5'd0, 0, 0);
    n_checks++;
    if (vec() !== 6'b100000) begin
      n_fail++; $display("FAIL no_regwrite: got %b want %b", vec(), 6'b100000);
    end
    tick();
  endtask

  task automatic test_flush();
    reset_dut();
    writer(5'd6); writer(5'd8); writer(5'd9);
    drive(1, 5'd8, 1, 5'd9, 1, 5'd0, 0, 1);
    n_checks++;
    if (vec() !== 6'b000000) begin
      n_fail++; $display("FAIL flush_over_stall: got %b want %b", vec(), 6'b000000);
    end
    tick();
    drive(1, 5'd6, 1, 5'd8, 1, 5'd0, 0, 0);
    n_checks++;
    if (vec() !== 6'b100010) begin
      n_fail++; $display("FAIL flush_keep_mem: got %b want %b", vec(), 6'b100010);
    end
    tick();
    drive(1, 5'd9, 1, 5'd9, 1, 5'd0, 0, 0);
    n_checks++;
    if (vec() !== 6'b100000) begin
      n_fail++; $display("FAIL flush_squashed: got %b want %b", vec(), 6'b100000);
    end
    tick();
    n_checks++;
    if (stall_cycles !== 16'd0) begin
      n_fail++; $display("FAIL flush_count: got %0d want 0", stall_cycles);
    end
  endtask

  task automatic test_reset_mid_stall();
    reset_dut();
    writer(5'd10);
    drive(1, 5'd10, 1, 5'd0, 0, 5'd0, 0, 0);
    tick();
    drive(1, 5'd10, 1, 5'd0, 0, 5'd0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (vec() !== 6'b0) begin
      n_fail++; $display("FAIL midreset_outputs: got %b want %b", vec(), 6'b0);
    end
    n_checks++;
    if (stall_cycles !== 16'd0) begin
      n_fail++; $display("FAIL midreset_count: got %0d want 0", stall_cycles);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete(); cyc = 0; exp_cnt = 0;
    drive(1, 5'd10, 1, 5'd10, 1, 5'd0, 0, 0);
    n_checks++;
    if (vec() !== 6'b100000) begin
      n_fail++; $display("FAIL post_reset_issue: got %b want %b", vec(), 6'b100000);
    end
    tick();
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(3) != 0), 5'($urandom_range(3)), 1'($urandom_range(1)),
            5'($urandom_range(3)), 1'($urandom_range(1)), 5'($urandom_range(3)),
            1'($urandom_range(1)), ($urandom_range(9) == 0));
      n_checks++;
      if (vec() !== exp_vec) begin
        n_fail++; $display("FAIL random_outputs cyc %0d: got %b want %b", i, vec(), exp_vec);
      end
      tick();
      n_checks++;
      if (stall_cycles !== 16'(exp_cnt)) begin
        n_fail++; $display("FAIL random_count cyc %0d: got %0d want %0d", i, stall_cycles, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mem_wb_fwd();
    test_stall();
    test_youngest_wins();
    test_no_hazard();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
